// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB-first frames with break recovery.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce_16,
    input  logic              ser_in,
`ifdef UART_RX_PARITY_EN
    input  logic              parity_odd,
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              new_rx_data,
    output logic              frame_err,
    output logic              rx_busy
);

    localparam int BCNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t              state_q;
    logic [1:0]          sync_q;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic [BCNT_W-1:0]   bcnt_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                new_q;
    logic                ferr_q;
    logic                ser_s;
    logic                mid;
    logic                last;
`ifdef UART_RX_PARITY_EN
    logic                par_bad_q;
    logic                perr_q;
`endif

    assign ser_s = sync_q[1];
    assign cnt_d = cnt_q + 4'd1;
    assign mid   = (cnt_q == 4'd7);
    assign last  = (cnt_q == 4'd15);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            bcnt_q    <= '0;
            shreg_q   <= '0;
            rx_data_q <= '0;
            new_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], ser_in};
            // Strobes clear every clock so they last one clock whatever the tick spacing.
            new_q  <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            if (ce_16) begin
                unique case (state_q)
                    IDLE: begin
                        if (!ser_s) begin
                            state_q <= START;
                            cnt_q   <= 4'd1;
                        end else begin
                            cnt_q   <= 4'd0;
                        end
                    end
                    START: begin
                        cnt_q <= cnt_d;
                        if (mid && ser_s) begin
                            state_q <= IDLE;
                            cnt_q   <= 4'd0;
                        end else if (last) begin
                            state_q <= DATA;
                            bcnt_q  <= '0;
                        end
                    end
                    DATA: begin
                        cnt_q <= cnt_d;
                        if (mid) begin
                            shreg_q <= {ser_s, shreg_q[DATA_W-1:1]};
                            bcnt_q  <= bcnt_q + 1'b1;
                        end
                        if (last && bcnt_q == BCNT_W'(DATA_W)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        cnt_q <= cnt_d;
                        if (mid)
                            par_bad_q <= ser_s ^ (^shreg_q) ^ parity_odd;
                        if (last)
                            state_q <= STOP;
                    end
`endif
                    STOP: begin
                        cnt_q <= cnt_d;
                        if (mid) begin
                            cnt_q <= 4'd0;
`ifdef UART_RX_PARITY_EN
                            perr_q <= par_bad_q;
`endif
                            if (ser_s) begin
                                state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                                if (!par_bad_q) begin
                                    rx_data_q <= shreg_q;
                                    new_q     <= 1'b1;
                                end
`else
                                rx_data_q <= shreg_q;
                                new_q     <= 1'b1;
`endif
                            end else begin
                                state_q <= BREAK;
                                ferr_q  <= 1'b1;
                            end
                        end
                    end
                    BREAK: begin
                        cnt_q <= 4'd0;
                        if (ser_s)
                            state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign new_rx_data = new_q;
    assign frame_err   = ferr_q;
    assign rx_busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a monitor pops and compares.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       ce_16;
    logic       ser_in;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
    logic       parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // kind bits: {parity_err, frame_err, new_rx_data}
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } ev_t;
    ev_t q[$];

    localparam logic [2:0] K_GOOD = 3'b001;
    localparam logic [2:0] K_FE   = 3'b010;
    localparam logic [2:0] K_PE   = 3'b100;

    uart_rx #(.DATA_W(8)) dut (
        .clock       (clk),
        .reset       (rst_n),
        .ce_16       (ce_16),
        .ser_in      (ser_in),
`ifdef UART_RX_PARITY_EN
        .parity_odd  (parity_odd),
        .parity_err  (parity_err),
`endif
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ce_16 = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 ce_16 = 1'b1;
            @(posedge clk);
            #1 ce_16 = 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] k;
        ev_t e;
`ifdef UART_RX_PARITY_EN
        k = {parity_err, frame_err, new_rx_data};
`else
        k = {1'b0, frame_err, new_rx_data};
`endif
        if (rst_n && k != 3'b000) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {29'd0, k}, 32'd0);
            end else begin
                e = q.pop_front();
                check("strobe_kind", {29'd0, k}, {29'd0, e.kind});
                check("strobe_data", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
    end

    task automatic bit_wait();
        repeat (64) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        ser_in = 1'b0;
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            ser_in = d[i];
            bit_wait();
        end
`ifdef UART_RX_PARITY_EN
        ser_in = ^d;
        bit_wait();
`endif
        ser_in = stop_b;
        bit_wait();
    endtask

    task automatic push(input logic [2:0] k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        #1;
        check(nm, q.size(), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        ser_in = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        #2;
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_strobes", {30'd0, new_rx_data, frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        bit_wait();
        check("idle_busy", {31'd0, rx_busy}, 32'd0);

        // clean byte
        push(K_GOOD, 8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("drain_a5");

        // back-to-back, no idle gap
        push(K_GOOD, 8'h00);
        push(K_GOOD, 8'hFF);
        push(K_GOOD, 8'h3C);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_drain("drain_b2b");

        // 3-tick glitch on idle line
        ser_in = 1'b0;
        repeat (12) @(posedge clk);
        #1 ser_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
        repeat (80) @(posedge clk);
        #1 check("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
        check("glitch_no_strobe", q.size(), 32'd0);

        // framing error followed by break
        push(K_FE, 8'h3C);
        send_frame(8'h55, 1'b0);
        repeat (40) bit_wait();
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        check("break_rx_data", {24'd0, rx_data}, 32'h3C);
        wait_drain("drain_fe");
        ser_in = 1'b1;
        bit_wait();
        bit_wait();
        check("break_exit_busy", {31'd0, rx_busy}, 32'd0);
        push(K_GOOD, 8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("drain_81");

        // reset in the middle of data bit 4 of 0xC3
        ser_in = 1'b0;
        bit_wait();
        for (int i = 0; i < 4; i++) begin
            ser_in = 1'(8'hC3 >> i);
            bit_wait();
        end
        ser_in = 1'b0;
        repeat (32) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_strobes", {30'd0, new_rx_data, frame_err}, 32'd0);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        ser_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        bit_wait();
        bit_wait();
        push(K_GOOD, 8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_drain("drain_5a");

`ifdef UART_RX_PARITY_EN
        // even parity: 0x07 has three ones, correct parity bit is 1
        push(K_GOOD, 8'h07);
        ser_in = 1'b0; bit_wait();
        for (int i = 0; i < 8; i++) begin ser_in = 1'(8'h07 >> i); bit_wait(); end
        ser_in = 1'b1; bit_wait();
        ser_in = 1'b1; bit_wait();
        wait_drain("drain_par_ok");
        push(K_PE, 8'h07);
        ser_in = 1'b0; bit_wait();
        for (int i = 0; i < 8; i++) begin ser_in = 1'(8'h07 >> i); bit_wait(); end
        ser_in = 1'b0; bit_wait();
        ser_in = 1'b1; bit_wait();
        wait_drain("drain_par_bad");
`endif

        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
